// File: rtl/axi_vip_loopback_chip.sv
// axi_vip_loopback_chip: AXI4 master traffic generator, pass-through monitor and memoryless slave.
// The master writes then reads NUM_TXN INCR bursts and checks each read beat against addr ^ A5A5_A5A5.
module axi_vip_loopback_chip #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                NUM_TXN   = 16,
    parameter int                BURST_LEN = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] wr_count,
    output logic [15:0] rd_count,
    output logic [15:0] err_count
);
    localparam int                BYTES    = DATA_W / 8;
    localparam logic [2:0]        SIZE     = 3'($clog2(BYTES));
    localparam logic [7:0]        LEN      = 8'(BURST_LEN - 1);
    localparam logic [15:0]       LAST_TXN = 16'(NUM_TXN > 0 ? NUM_TXN - 1 : 0);
    localparam logic [DATA_W-1:0] PATTERN  = DATA_W'(32'hA5A5_A5A5);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic [3:0]        id;
    } ax_t;

    typedef enum logic [2:0] {IDLE, WADDR, WDATA, WRESP, RADDR, RDATA, FIN} state_t;

    ax_t                m_aw, s_aw, m_ar, s_ar;
    logic               m_awvalid, s_awvalid, m_awready, s_awready;
    logic               m_wvalid, s_wvalid, m_wready, s_wready, m_wlast, s_wlast;
    logic [DATA_W-1:0]  m_wdata, s_wdata;
    logic [BYTES-1:0]   m_wstrb, s_wstrb;
    logic               m_bvalid, s_bvalid, m_bready, s_bready;
    logic [1:0]         m_bresp, s_bresp;
    logic [3:0]         m_bid, s_bid;
    logic               m_arvalid, s_arvalid, m_arready, s_arready;
    logic               m_rvalid, s_rvalid, m_rready, s_rready, m_rlast, s_rlast;
    logic [DATA_W-1:0]  m_rdata, s_rdata;
    logic [1:0]         m_rresp, s_rresp;
    logic [3:0]         m_rid, s_rid;

    state_t             state, state_nx;
    logic [15:0]        txn;
    logic [7:0]         beat;
    logic [ADDR_W-1:0]  beat_addr;
    logic [DATA_W-1:0]  beat_data;
    logic               last_beat, last_txn, clr, pass_q;
    logic [1:0]         err_inc;
    logic [16:0]        err_sum;

    assign beat_addr = BASE_ADDR + ADDR_W'(txn) * ADDR_W'(BURST_LEN * BYTES) + ADDR_W'(beat) * ADDR_W'(BYTES);
    assign beat_data = DATA_W'(beat_addr);
    assign last_beat = beat == LEN;
    assign last_txn  = txn == LAST_TXN;
    assign clr       = state == IDLE && start;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? (NUM_TXN == 0 ? FIN : WADDR) : IDLE;
            WADDR:   state_nx = m_awready ? WDATA : WADDR;
            WDATA:   state_nx = m_wready && last_beat ? WRESP : WDATA;
            WRESP:   state_nx = m_bvalid ? (last_txn ? RADDR : WADDR) : WRESP;
            RADDR:   state_nx = m_arready ? RDATA : RADDR;
            RDATA:   state_nx = m_rvalid && m_rlast ? (last_txn ? FIN : RADDR) : RDATA;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        m_awvalid = state == WADDR;
        m_aw      = '{addr: beat_addr, len: LEN, size: SIZE, burst: 2'b01, id: 4'd0};
        m_wvalid  = state == WDATA;
        m_wdata   = beat_data;
        m_wstrb   = '1;
        m_wlast   = last_beat;
        m_bready  = state == WRESP;
        m_arvalid = state == RADDR;
        m_ar      = '{addr: beat_addr, len: LEN, size: SIZE, burst: 2'b01, id: 4'd0};
        m_rready  = state == RDATA;
        busy      = state != IDLE;
        done      = state == FIN;
        pass      = state == FIN ? err_count == '0 : pass_q;
    end

    // A single read beat can carry a data, a response and an RLAST error at once.
    always_comb begin
        err_inc = m_rvalid && m_rready ? 2'(m_rdata != (beat_data ^ PATTERN)) + 2'(m_rresp != 2'b00) + 2'(m_rlast && !last_beat)
                : m_bvalid && m_bready ? 2'(m_bresp != 2'b00) : 2'd0;
        err_sum = {1'b0, err_count} + 17'(err_inc);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            txn       <= '0;
            beat      <= '0;
            err_count <= '0;
            pass_q    <= 1'b0;
        end else if (clr) begin
            txn       <= '0;
            beat      <= '0;
            err_count <= '0;
            pass_q    <= 1'b0;
        end else begin
            if (m_wvalid && m_wready)
                beat <= last_beat ? 8'd0 : beat + 8'd1;
            if (m_bvalid && m_bready)
                txn <= last_txn ? 16'd0 : txn + 16'd1;
            if (m_rvalid && m_rready) begin
                beat <= m_rlast ? 8'd0 : beat + 8'd1;
                txn  <= m_rlast ? txn + 16'd1 : txn;
            end
            err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
            if (state == FIN)
                pass_q <= err_count == '0;
        end
    end

    // Monitor: straight wires between master and slave, plus handshake counters.
    assign s_awvalid = m_awvalid;
    assign s_aw      = m_aw;
    assign m_awready = s_awready;
    assign s_wvalid  = m_wvalid;
    assign s_wdata   = m_wdata;
    assign s_wstrb   = m_wstrb;
    assign s_wlast   = m_wlast;
    assign m_wready  = s_wready;
    assign m_bvalid  = s_bvalid;
    assign m_bresp   = s_bresp;
    assign m_bid     = s_bid;
    assign s_bready  = m_bready;
    assign s_arvalid = m_arvalid;
    assign s_ar      = m_ar;
    assign m_arready = s_arready;
    assign m_rvalid  = s_rvalid;
    assign m_rdata   = s_rdata;
    assign m_rresp   = s_rresp;
    assign m_rid     = s_rid;
    assign m_rlast   = s_rlast;
    assign s_rready  = m_rready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_count <= '0;
            rd_count <= '0;
        end else if (clr) begin
            wr_count <= '0;
            rd_count <= '0;
        end else begin
            if (m_bvalid && m_bready && wr_count != 16'hFFFF)
                wr_count <= wr_count + 16'd1;
            if (m_rvalid && m_rready && m_rlast && rd_count != 16'hFFFF)
                rd_count <= rd_count + 16'd1;
        end
    end

    // Slave: accepts one burst per direction at a time and synthesises read data from the address.
    logic              w_active, r_active, r_fixed;
    logic [ADDR_W-1:0] aw_addr, r_addr, r_beat_addr;
    logic [3:0]        aw_id, r_id;
    logic [7:0]        r_len, r_beat;
    logic [2:0]        r_size;
    logic              unused_ok;

    assign s_wready    = w_active;
    assign s_bresp     = 2'b00;
    assign s_bid       = aw_id;
    assign s_rvalid    = r_active;
    assign r_beat_addr = r_addr + (r_fixed ? '0 : ADDR_W'(r_beat) << r_size);
    assign s_rdata     = DATA_W'(r_beat_addr) ^ PATTERN;
    assign s_rresp     = 2'b00;
    assign s_rid       = r_id;
    assign s_rlast     = r_beat == r_len;
    assign unused_ok   = &{1'b0, aw_addr, s_aw.len, s_aw.size, s_aw.burst, s_wdata, s_wstrb, m_bid, m_rid};

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s_awready <= 1'b0;
            w_active  <= 1'b0;
            s_bvalid  <= 1'b0;
            aw_addr   <= '0;
            aw_id     <= '0;
        end else begin
            s_awready <= s_awvalid && !s_awready && !w_active && !s_bvalid;
            if (s_awvalid && s_awready) begin
                w_active <= 1'b1;
                aw_addr  <= s_aw.addr;
                aw_id    <= s_aw.id;
            end
            if (s_wvalid && s_wready && s_wlast) begin
                w_active <= 1'b0;
                s_bvalid <= 1'b1;
            end
            if (s_bvalid && s_bready)
                s_bvalid <= 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s_arready <= 1'b0;
            r_active  <= 1'b0;
            r_addr    <= '0;
            r_len     <= '0;
            r_size    <= '0;
            r_id      <= '0;
            r_beat    <= '0;
            r_fixed   <= 1'b0;
        end else begin
            s_arready <= s_arvalid && !s_arready && !r_active;
            if (s_arvalid && s_arready) begin
                r_active <= 1'b1;
                r_addr   <= s_ar.addr;
                r_len    <= s_ar.len;
                r_size   <= s_ar.size;
                r_id     <= s_ar.id;
                r_beat   <= '0;
                r_fixed  <= s_ar.burst == 2'b00;
            end
            if (s_rvalid && s_rready) begin
                r_beat <= r_beat + 8'd1;
                if (s_rlast)
                    r_active <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_axi_vip_loopback_chip.sv
// tb_axi_vip_loopback_chip: randomized runs of the loopback chip checked against an address-formula model.
module tb_axi_vip_loopback_chip;
    localparam int          NUM_TXN   = 16;
    localparam int          BURST_LEN = 4;
    localparam logic [31:0] BASE      = 32'h0;
    localparam logic [31:0] PAT       = 32'hA5A5_A5A5;

    logic        aclk = 1'b0, aresetn = 1'b0, start = 1'b0;
    logic        busy, done, pass;
    logic [15:0] wr_count, rd_count, err_count;
    int          n_chk = 0, n_err = 0, done_cnt = 0;
    int          wk = 0, wb = 0, rk = 0, rb = 0;

    axi_vip_loopback_chip #(
        .ADDR_W(32), .DATA_W(32), .NUM_TXN(NUM_TXN), .BURST_LEN(BURST_LEN), .BASE_ADDR(BASE)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .start(start), .busy(busy), .done(done), .pass(pass),
        .wr_count(wr_count), .rd_count(rd_count), .err_count(err_count)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] addr_of(input int k, input int b);
        return BASE + 32'(k * BURST_LEN * 4 + b * 4);
    endfunction

    function automatic logic [63:0] ax_of(input int k);
        return {15'b0, addr_of(k, 0), 8'(BURST_LEN - 1), 3'd2, 2'b01, 4'd0};
    endfunction

    // Scoreboard on the slave side of the link: every handshake against the address formula.
    always @(negedge aclk) begin
        if (done)
            done_cnt++;
        if (!aresetn || !busy) begin
            wk = 0; wb = 0; rk = 0; rb = 0;
        end else begin
            if (dut.s_awvalid && dut.s_awready)
                chk("aw", 64'(dut.s_aw), ax_of(wk));
            if (dut.s_wvalid && dut.s_wready) begin
                chk("wdata", 64'(dut.s_wdata), 64'(addr_of(wk, wb)));
                chk("wlast", 64'(dut.s_wlast), 64'(wb == BURST_LEN - 1));
                wb++;
            end
            if (dut.s_bvalid && dut.s_bready) begin
                chk("bresp", 64'(dut.s_bresp), 64'd0);
                chk("wbeats", 64'(wb), 64'(BURST_LEN));
                wk++; wb = 0;
            end
            if (dut.s_arvalid && dut.s_arready)
                chk("ar", 64'(dut.s_ar), ax_of(rk));
            if (dut.s_rvalid && dut.s_rready) begin
                chk("rdata", 64'(dut.s_rdata), 64'(addr_of(rk, rb) ^ PAT));
                chk("rlast", 64'(dut.s_rlast), 64'(rb == BURST_LEN - 1));
                if (rk == 2 && rb == 1)
                    chk("rdata_b2_beat1", 64'(dut.s_rdata), 64'hA5A5_A581);
                if (dut.s_rlast) begin
                    rk++; rb = 0;
                end else
                    rb++;
            end
        end
    end

    task automatic start_run(output int d0);
        repeat ($urandom_range(1, 6)) @(negedge aclk);
        d0 = done_cnt;
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
    endtask

    task automatic finish_run(input string tag, input int exp_err, input int d0, input bit start_at_done);
        bit seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge aclk);
            seen = done;
        end
        chk({tag, "_done_seen"}, 64'(seen), 64'd1);
        start = start_at_done;
        chk({tag, "_pass_at_done"}, 64'(pass), 64'(exp_err == 0));
        chk({tag, "_wr_count"}, 64'(wr_count), 64'(NUM_TXN));
        chk({tag, "_rd_count"}, 64'(rd_count), 64'(NUM_TXN));
        chk({tag, "_err_count"}, 64'(err_count), 64'(exp_err));
        @(negedge aclk);
        start = 1'b0;
        repeat (10) @(negedge aclk);
        chk({tag, "_done_once"}, 64'(done_cnt - d0), 64'd1);
        chk({tag, "_idle"}, 64'(busy), 64'd0);
        chk({tag, "_pass_held"}, 64'(pass), 64'(exp_err == 0));
        chk({tag, "_counts_held"}, 64'({wr_count, rd_count}), 64'({16'(NUM_TXN), 16'(NUM_TXN)}));
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_pass"}, 64'(pass), 64'd0);
        chk({tag, "_counts"}, 64'({wr_count, rd_count, err_count}), 64'd0);
        chk({tag, "_valids"}, 64'({dut.m_awvalid, dut.m_arvalid, dut.m_wvalid, dut.m_rready, dut.m_bready}), 64'd0);
    endtask

    initial begin
        int          d0, tgt, cnt, nb, bi, rbeat;
        logic [31:0] fv;
        bit          hit;
        repeat (5) @(negedge aclk);
        chk_reset_state("in_reset");
        aresetn = 1'b1;
        repeat (3) @(negedge aclk);
        chk_reset_state("after_reset");

        start_run(d0);
        finish_run("run1", 0, d0, 1'b0);

        // A start during WDATA is ignored; a start coinciding with done is dropped.
        start_run(d0);
        hit = 1'b0;
        for (int i = 0; i < 500 && !hit; i++) begin
            @(negedge aclk);
            hit = dut.m_wvalid;
        end
        chk("busy_wdata_seen", 64'(hit), 64'd1);
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        finish_run("busy_start", 0, d0, 1'b1);

        // One flipped bit on one randomly chosen read beat, seen only by the master.
        start_run(d0);
        tgt = int'($urandom_range(0, NUM_TXN * BURST_LEN - 1));
        fv = (BASE + 32'(tgt * 4)) ^ PAT ^ (32'd1 << $urandom_range(0, 31));
        cnt = 0;
        hit = 1'b0;
        for (int i = 0; i < 3000 && !hit; i++) begin
            @(negedge aclk);
            if (dut.m_rvalid && dut.m_rready) begin
                if (cnt == tgt) begin
                    hit = 1'b1;
                    force dut.m_rdata = fv;
                    @(posedge aclk);
                    #1 release dut.m_rdata;
                end
                cnt++;
            end
        end
        chk("fault_applied", 64'(hit), 64'd1);
        finish_run("fault", 1, d0, 1'b0);

        // Reset during a random beat of read burst 5.
        start_run(d0);
        rbeat = int'($urandom_range(0, BURST_LEN - 1));
        nb = 0; bi = 0;
        hit = 1'b0;
        for (int i = 0; i < 3000 && !hit; i++) begin
            @(negedge aclk);
            if (dut.m_rvalid && dut.m_rready) begin
                if (nb == 5 && bi == rbeat)
                    hit = 1'b1;
                else if (dut.m_rlast) begin
                    nb++; bi = 0;
                end else
                    bi++;
            end
        end
        chk("midrst_reached", 64'(hit), 64'd1);
        aresetn = 1'b0;
        #1;
        chk_reset_state("midrst");
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        repeat (20) @(negedge aclk);
        chk("midrst_no_done", 64'(done_cnt - d0), 64'd0);
        chk_reset_state("midrst_idle");
        start_run(d0);
        finish_run("after_midrst", 0, d0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/axi_vip_loopback_chip.md
Name: axi_vip_loopback_chip

Overview:
- Self-contained AXI4 subsystem with three internal parts: a master traffic generator, a passive pass-through monitor, and a slave responder with no memory.
- The master issues NUM_TXN write bursts, then NUM_TXN read bursts, and checks each read beat against a deterministic pattern.
- The monitor counts handshakes on the link.
- Only the clock, reset, a start pulse and status outputs leave the block; it is the top of the VIP example bench.

Parameters:
- ADDR_W, 32, AXI address width.
- DATA_W, 32, AXI data width (multiple of 8).
- NUM_TXN, 16, write bursts, and separately read bursts, per run.
- BURST_LEN, 4, beats per INCR burst (1..16); AxLEN = BURST_LEN-1.
- BASE_ADDR, 32'h0000_0000, address of the first burst.

Ports:
- aclk  in  1  single clock; all logic on its rising edge.
- aresetn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; starts a run when idle. Ignored while busy.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the last read beat has been checked.
- pass  out  1  after done: high iff err_count==0; held until the next start.
- wr_count  out  16  write responses seen by the monitor (B handshakes).
- rd_count  out  16  read bursts seen by the monitor (R handshakes with RLAST).
- err_count  out  16  read data mismatches plus non-OKAY responses.

Behaviour:
- Reset (async assert, sync deassert):
  - All VALID/READY signals low.
  - busy=0, done=0, pass=0; all counters 0.
  - Master FSM in IDLE.
- Master FSM: IDLE -> WADDR -> WDATA -> WRESP -> (next write burst, or RADDR) -> RDATA -> (next read burst, or FIN) -> IDLE.
  - start in IDLE clears all counters and pass, and moves to WADDR.
  - FIN asserts done for one cycle.
  - Burst k (0..NUM_TXN-1) uses address BASE_ADDR + k*BURST_LEN*(DATA_W/8).
  - Fixed signals: AxBURST=INCR, AxSIZE=log2(DATA_W/8), AxID=0.
- Write channel:
  - AWVALID is held until AWREADY; address and control are stable while VALID is high.
  - W beats start only after the AW handshake.
  - Beat data = beat address; WSTRB = all ones; WLAST on beat BURST_LEN-1.
  - WVALID is held until WREADY.
  - BREADY is high in WRESP.
- Read channel:
  - ARVALID is held until ARREADY.
  - RREADY is high in RDATA.
  - Each R beat is compared to (beat address ^ 32'hA5A5_A5A5, truncated/zero-extended to DATA_W).
  - err_count increments once per mismatching beat.
  - err_count also increments once per BRESP or RRESP that is not OKAY.
  - RLAST arriving on the wrong beat counts as one error; the burst still ends at RLAST.
- Slave responder (no storage):
  - AWREADY asserts one cycle after AWVALID and the address is captured.
  - WREADY is high while beats remain; data is discarded.
  - After the WLAST handshake, BVALID is asserted next cycle with BRESP=OKAY and BID=AWID.
  - ARREADY asserts one cycle after ARVALID.
  - R beats are driven back-to-back when RREADY allows.
  - RDATA = beat address ^ 32'hA5A5_A5A5; RRESP=OKAY; RLAST on the final beat.
  - VALID is held until READY.
  - One outstanding transaction per channel direction.
- Pass-through monitor:
  - Wires every signal straight through with no added latency.
  - Counts BVALID&&BREADY into wr_count and RVALID&&RREADY&&RLAST into rd_count.
  - Counters saturate at 16'hFFFF.
- Latency:
  - Minimum write burst: 1 AW cycle + 1 response-ready cycle, then BURST_LEN W beats, then 1 B cycle.
  - Read burst: AR + 1 cycle, then BURST_LEN R beats.
- Edge cases:
  - start while busy: ignored.
  - Simultaneous start and done: done wins, start is dropped.
  - aresetn low mid-run: immediate return to reset state; no done, pass=0; a new start is needed.
  - NUM_TXN=0: done asserted the cycle after start with pass=1.

Test Plan:
- Reset: hold aresetn=0 for 5 cycles, release; before start -> all outputs 0, AWVALID=ARVALID=0.
- Default run (NUM_TXN=16, BURST_LEN=4): start pulse -> done exactly once; wr_count=16, rd_count=16, err_count=0, pass=1.
- Address pattern: on read burst 2 at BASE 0, beat 1 address is 0x24 -> RDATA=0xA5A5_A581, RLAST on beat 3 only.
- Fault injection: force one RDATA bit on a single beat -> err_count=1, pass=0 after done.
- Mid-run reset: assert aresetn=0 during RDATA of burst 5 -> counters 0, busy=0, no done; a fresh start -> full pass with counts 16/16.
- Start while busy: second start pulse during WDATA -> ignored; exactly one done, counts 16/16.
